// File: rtl/rx_frame_reader_if.sv
// Payload stream from rx_frame_reader to its consumer: valid/ready handshake with last/err.
interface rx_frame_reader_if;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic        m_err;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        output m_err,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        input  m_err,
        output m_ready
    );
endinterface

// File: rtl/rx_frame_reader.sv
// Drains received MAC frames from the rx FIFO, filters on EtherType and streams the payload.
// Optional stall timeout with a synthetic error word is enabled by defining RX_TIMEOUT_EN.
module rx_frame_reader #(
    parameter int CLEAR_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk_100_mhz,
    input  logic                     rst,
    input  logic                     rx_ready,
    input  logic [31:0]              rx_data,
    output logic                     rx_read_en,
    input  logic                     rx_empty,
    input  logic [15:0]              rx_data_count,
    input  logic [15:0]              rx_protocol_type,
    output logic                     rx_clear,
    input  logic                     filter_en,
    input  logic [15:0]              filter_type,
    rx_frame_reader_if.master        m_if,
    output logic [15:0]              frame_count,
    output logic [15:0]              drop_count
);
    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        STREAM,
        CLEAR,
        WAIT_LOW
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [15:0] words_left;
    logic [31:0] buf_data [2];
    logic [1:0]  buf_last;
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  occ;
    logic [1:0]  occ_next;
    logic        rd_pending;
    logic        rd_pending_last;
    logic [3:0]  clr_cnt;
    logic        pop;
    logic        pop_buf;
    logic        reject;

    logic [31:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_err;

`ifdef RX_TIMEOUT_EN
    logic [15:0] stall_cnt;
    logic        timed_out;

    assign timed_out = (stall_cnt == 16'(TIMEOUT_CYCLES));
`endif

    assign reject = (rx_data_count == 16'd0) ||
                    (filter_en && (rx_protocol_type != filter_type));

    always_ff @(posedge clk_100_mhz) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Reads are allowed only while the buffer plus the in-flight read still fit in two entries.
    always_comb begin
        state_next = state;
        rx_read_en = 1'b0;
        out_data   = 32'd0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        out_err    = 1'b0;
        pop        = 1'b0;
        pop_buf    = 1'b0;
        occ_next   = occ + {1'b0, rd_pending};

        case (state)
            IDLE: begin
                if (rx_ready) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                state_next = reject ? CLEAR : STREAM;
            end
            STREAM: begin
                if (occ != 2'd0) begin
                    out_valid = 1'b1;
                    out_data  = buf_data[rd_ptr];
                    out_last  = buf_last[rd_ptr];
`ifdef RX_TIMEOUT_EN
                end else if (timed_out && !rd_pending) begin
                    out_valid = 1'b1;
                    out_last  = 1'b1;
                    out_err   = 1'b1;
`endif
                end
                pop      = out_valid && m_if.m_ready;
                pop_buf  = pop && (occ != 2'd0);
                occ_next = occ + {1'b0, rd_pending} - {1'b0, pop_buf};
                if (!rx_empty && (words_left != 16'd0) && (occ_next < 2'd2)
`ifdef RX_TIMEOUT_EN
                    && !timed_out
`endif
                   ) begin
                    rx_read_en = 1'b1;
                end
                if (pop && out_last) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                if (clr_cnt == 4'(CLEAR_CYCLES - 1)) begin
                    state_next = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (!rx_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_100_mhz) begin
        if (rst) begin
            words_left      <= 16'd0;
            buf_data[0]     <= 32'd0;
            buf_data[1]     <= 32'd0;
            buf_last        <= 2'b00;
            wr_ptr          <= 1'b0;
            rd_ptr          <= 1'b0;
            occ             <= 2'd0;
            rd_pending      <= 1'b0;
            rd_pending_last <= 1'b0;
            clr_cnt         <= 4'd0;
            frame_count     <= 16'd0;
            drop_count      <= 16'd0;
        end else begin
            rd_pending      <= rx_read_en;
            rd_pending_last <= rx_read_en && (words_left == 16'd1);

            if (state == CHECK) begin
                words_left <= rx_data_count;
                if (reject) begin
                    drop_count <= drop_count + 16'd1;
                end
            end else if (rx_read_en) begin
                words_left <= words_left - 16'd1;
            end

            if (state == STREAM) begin
                if (rd_pending) begin
                    buf_data[wr_ptr] <= rx_data;
                    buf_last[wr_ptr] <= rd_pending_last;
                    wr_ptr           <= ~wr_ptr;
                end
                if (pop_buf) begin
                    rd_ptr <= ~rd_ptr;
                end
                occ <= occ_next;
                if (pop && out_last) begin
                    if (out_err) begin
                        drop_count <= drop_count + 16'd1;
                    end else begin
                        frame_count <= frame_count + 16'd1;
                    end
                end
            end else begin
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
                occ    <= 2'd0;
            end

            clr_cnt <= (state == CLEAR) ? clr_cnt + 4'd1 : 4'd0;
        end
    end

`ifdef RX_TIMEOUT_EN
    // Only genuine FIFO starvation counts as a stall; a full output buffer does not.
    always_ff @(posedge clk_100_mhz) begin
        if (rst || (state != STREAM) || rx_read_en) begin
            stall_cnt <= 16'd0;
        end else if ((words_left != 16'd0) && rx_empty && !timed_out) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

    assign rx_clear      = (state == CLEAR);
    assign m_if.m_data   = out_data;
    assign m_if.m_valid  = out_valid;
    assign m_if.m_last   = out_last;
    assign m_if.m_err    = out_err;
endmodule

// File: tb/tb_rx_frame_reader.sv
// Directed bench for rx_frame_reader: FIFO model with 1-cycle read latency, output monitor,
// hand-computed expectations. The timeout scenario runs only when RX_TIMEOUT_EN is defined.
module tb_rx_frame_reader;
    logic        clk_100_mhz = 1'b0;
    logic        rst = 1'b1;
    logic        rx_ready = 1'b0;
    logic [31:0] rx_data = 32'd0;
    logic        rx_read_en;
    logic        rx_empty;
    logic [15:0] rx_data_count = 16'd0;
    logic [15:0] rx_protocol_type = 16'd0;
    logic        rx_clear;
    logic        filter_en = 1'b0;
    logic [15:0] filter_type = 16'h0800;
    logic [15:0] frame_count;
    logic [15:0] drop_count;

    int total = 0;
    int bad = 0;

    logic [31:0] fifo_mem [64];
    int          fifo_wr = 0;
    int          fifo_rd = 0;
    logic        fifo_flush = 1'b0;

    int          cyc = 0;
    int          n_reads = 0;
    int          n_rd_empty = 0;
    int          n_unstable = 0;
    int          log_n = 0;
    logic [31:0] log_data [64];
    logic        log_last [64];
    logic        log_err  [64];
    int          log_cyc  [64];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = 32'd0;
    logic        prev_last = 1'b0;

    int exp_frames = 0;
    int exp_drops = 0;

    always #5 clk_100_mhz = ~clk_100_mhz;

    rx_frame_reader_if m_if();

    rx_frame_reader #(
        .CLEAR_CYCLES   (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_100_mhz      (clk_100_mhz),
        .rst              (rst),
        .rx_ready         (rx_ready),
        .rx_data          (rx_data),
        .rx_read_en       (rx_read_en),
        .rx_empty         (rx_empty),
        .rx_data_count    (rx_data_count),
        .rx_protocol_type (rx_protocol_type),
        .rx_clear         (rx_clear),
        .filter_en        (filter_en),
        .filter_type      (filter_type),
        .m_if             (m_if.master),
        .frame_count      (frame_count),
        .drop_count       (drop_count)
    );

    assign rx_empty = (fifo_rd == fifo_wr);

    // FIFO read side: data appears the cycle after the pop request.
    always @(posedge clk_100_mhz) begin
        if (fifo_flush) begin
            fifo_rd <= fifo_wr;
        end else if (rx_read_en && !rx_empty) begin
            rx_data <= fifo_mem[fifo_rd];
            fifo_rd <= fifo_rd + 1;
        end
    end

    always @(negedge clk_100_mhz) begin
        cyc = cyc + 1;
        if (rx_read_en) n_reads = n_reads + 1;
        if (rx_read_en && rx_empty) n_rd_empty = n_rd_empty + 1;
        if (prev_stall && m_if.m_valid &&
            ((m_if.m_data != prev_data) || (m_if.m_last != prev_last)))
            n_unstable = n_unstable + 1;
        if (m_if.m_valid && m_if.m_ready && log_n < 64) begin
            log_data[log_n] = m_if.m_data;
            log_last[log_n] = m_if.m_last;
            log_err[log_n]  = m_if.m_err;
            log_cyc[log_n]  = cyc;
            log_n = log_n + 1;
        end
        prev_stall = m_if.m_valid && !m_if.m_ready;
        prev_data  = m_if.m_data;
        prev_last  = m_if.m_last;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        total = total + 1;
        if (actual !== expected) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk_100_mhz);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] count, input logic [15:0] ptype,
                                 input int nwords, input logic [31:0] first);
        for (int i = 0; i < nwords; i++) begin
            fifo_mem[fifo_wr] = first + 32'(i);
            fifo_wr = fifo_wr + 1;
        end
        rx_data_count    = count;
        rx_protocol_type = ptype;
        rx_ready         = 1'b1;
    endtask

    // Waits for the clear pulse, measures it, then drops rx_ready and empties the FIFO.
    task automatic finishFrame(input string tag, output int clr_len);
        int waited;
        waited  = 0;
        clr_len = 0;
        while (!rx_clear && waited < 200) begin
            tick();
            waited++;
        end
        if (!rx_clear) checkOutput({tag, "_clear_seen"}, 32'd0, 32'd1);
        while (rx_clear && clr_len < 32) begin
            clr_len++;
            tick();
        end
        rx_ready   = 1'b0;
        fifo_flush = 1'b1;
        tick();
        fifo_flush = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        int base;
        int rd0;
        int unst0;
        int clr_len;
        int waited;

        m_if.m_ready = 1'b1;
        repeat (3) tick();
        checkOutput("rst_valid",  {31'd0, m_if.m_valid}, 32'd0);
        checkOutput("rst_read",   {31'd0, rx_read_en}, 32'd0);
        checkOutput("rst_clear",  {31'd0, rx_clear}, 32'd0);
        checkOutput("rst_data",   m_if.m_data, 32'd0);
        checkOutput("rst_frames", {16'd0, frame_count}, 32'd0);
        checkOutput("rst_drops",  {16'd0, drop_count}, 32'd0);
        rst = 1'b0;
        tick();

        $display("[TB] frame of 3 words, no filter");
        base = log_n;
        applyStimulus(16'd3, 16'h86DD, 3, 32'hA000_0001);
        finishFrame("t1", clr_len);
        exp_frames++;
        checkOutput("t1_words", 32'(log_n - base), 32'd3);
        checkOutput("t1_w0", log_data[base], 32'hA000_0001);
        checkOutput("t1_w2", log_data[base+2], 32'hA000_0003);
        checkOutput("t1_lasts", {29'd0, log_last[base], log_last[base+1], log_last[base+2]}, 32'd1);
        checkOutput("t1_back2back", 32'(log_cyc[base+2] - log_cyc[base]), 32'd2);
        checkOutput("t1_frames", {16'd0, frame_count}, 32'(exp_frames));
        checkOutput("t1_clear_len", 32'(clr_len), 32'd4);

        $display("[TB] filtered frame");
        filter_en   = 1'b1;
        filter_type = 16'h0800;
        base = log_n;
        rd0  = n_reads;
        applyStimulus(16'd5, 16'h0806, 5, 32'hB000_0001);
        finishFrame("t2", clr_len);
        exp_drops++;
        filter_en = 1'b0;
        checkOutput("t2_reads", 32'(n_reads - rd0), 32'd0);
        checkOutput("t2_words", 32'(log_n - base), 32'd0);
        checkOutput("t2_drops", {16'd0, drop_count}, 32'(exp_drops));
        checkOutput("t2_frames", {16'd0, frame_count}, 32'(exp_frames));
        checkOutput("t2_clear_len", 32'(clr_len), 32'd4);

        $display("[TB] backpressure on a 4-word frame");
        filter_en = 1'b1;
        base  = log_n;
        rd0   = n_reads;
        unst0 = n_unstable;
        applyStimulus(16'd4, 16'h0800, 4, 32'hC000_0001);
        waited = 0;
        while (log_n == base && waited < 50) begin
            tick();
            waited++;
        end
        m_if.m_ready = 1'b0;
        repeat (10) tick();
        checkOutput("t3_reads_stalled", 32'(n_reads - rd0), 32'd3);
        checkOutput("t3_held_valid", {31'd0, m_if.m_valid}, 32'd1);
        checkOutput("t3_held_data", m_if.m_data, 32'hC000_0002);
        m_if.m_ready = 1'b1;
        finishFrame("t3", clr_len);
        filter_en = 1'b0;
        exp_frames++;
        checkOutput("t3_words", 32'(log_n - base), 32'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("t3_w%0d", i), log_data[base+i], 32'hC000_0001 + 32'(i));
            checkOutput($sformatf("t3_last%0d", i), {31'd0, log_last[base+i]}, (i == 3) ? 32'd1 : 32'd0);
        end
        checkOutput("t3_stable", 32'(n_unstable - unst0), 32'd0);
        checkOutput("t3_frames", {16'd0, frame_count}, 32'(exp_frames));

        $display("[TB] zero-length frame");
        rd0 = n_reads;
        applyStimulus(16'd0, 16'h0800, 0, 32'd0);
        finishFrame("t4", clr_len);
        exp_drops++;
        checkOutput("t4_reads", 32'(n_reads - rd0), 32'd0);
        checkOutput("t4_drops", {16'd0, drop_count}, 32'(exp_drops));
        checkOutput("t4_clear_len", 32'(clr_len), 32'd4);

`ifdef RX_TIMEOUT_EN
        $display("[TB] starved frame hits the timeout");
        base = log_n;
        applyStimulus(16'd4, 16'h0800, 2, 32'hD000_0001);
        finishFrame("t5", clr_len);
        exp_drops++;
        checkOutput("t5_words", 32'(log_n - base), 32'd3);
        checkOutput("t5_w0", log_data[base], 32'hD000_0001);
        checkOutput("t5_w1", log_data[base+1], 32'hD000_0002);
        checkOutput("t5_flags01", {28'd0, log_last[base], log_err[base], log_last[base+1], log_err[base+1]}, 32'd0);
        checkOutput("t5_synth_data", log_data[base+2], 32'd0);
        checkOutput("t5_synth_flags", {30'd0, log_last[base+2], log_err[base+2]}, 32'd3);
        checkOutput("t5_drops", {16'd0, drop_count}, 32'(exp_drops));
        checkOutput("t5_frames", {16'd0, frame_count}, 32'(exp_frames));
        checkOutput("t5_clear_len", 32'(clr_len), 32'd4);
`endif

        $display("[TB] reset in the middle of a frame");
        m_if.m_ready = 1'b0;
        applyStimulus(16'd4, 16'h0800, 1, 32'hE000_0001);
        waited = 0;
        while (!m_if.m_valid && waited < 20) begin
            tick();
            waited++;
        end
        checkOutput("t6_pre_valid", {31'd0, m_if.m_valid}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("t6_valid", {31'd0, m_if.m_valid}, 32'd0);
        checkOutput("t6_read", {31'd0, rx_read_en}, 32'd0);
        checkOutput("t6_clear", {31'd0, rx_clear}, 32'd0);
        checkOutput("t6_frames", {16'd0, frame_count}, 32'd0);
        checkOutput("t6_drops", {16'd0, drop_count}, 32'd0);
        rx_ready   = 1'b0;
        fifo_flush = 1'b1;
        tick();
        fifo_flush = 1'b0;
        repeat (3) tick();
        checkOutput("t6_idle_clear", {31'd0, rx_clear}, 32'd0);
        checkOutput("rd_while_empty", 32'(n_rd_empty), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got still running, want finished");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
